// File: rtl/fpu_issue_unit.sv
// FP issue/writeback unit: owns the FP register file and busy scoreboard, issues
// tagged ops to a multi-cycle FPU and retires out-of-order tagged responses.
module fpu_issue_unit #(
    parameter  int DATA_W          = 32,
    parameter  int NUM_REGS        = 32,
    parameter  int OP_W            = 5,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int ADDR_W          = $clog2(NUM_REGS),
    localparam int TAG_W           = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [OP_W-1:0]   req_op_i,
    input  logic [2:0]        req_rm_i,
    input  logic [ADDR_W-1:0] req_rs1_i,
    input  logic [ADDR_W-1:0] req_rs2_i,
    input  logic [ADDR_W-1:0] req_rs3_i,
    input  logic              req_use_rs3_i,
    input  logic [4:0]        req_rd_i,
    input  logic              req_rd_int_i,

    output logic              fpu_valid_o,
    input  logic              fpu_ready_i,
    output logic [OP_W-1:0]   fpu_op_o,
    output logic [2:0]        fpu_rm_o,
    output logic [DATA_W-1:0] fpu_a_o,
    output logic [DATA_W-1:0] fpu_b_o,
    output logic [DATA_W-1:0] fpu_c_o,
    output logic [TAG_W-1:0]  fpu_tag_o,

    input  logic              fpu_resp_valid_i,
    input  logic [TAG_W-1:0]  fpu_resp_tag_i,
    input  logic [DATA_W-1:0] fpu_resp_data_i,

    output logic              int_we_o,
    output logic [4:0]        int_waddr_o,
    output logic [DATA_W-1:0] int_wdata_o,

    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_waddr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,

    input  logic [ADDR_W-1:0] dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o,

    output logic [CNT_W-1:0]  outstanding_o,
    output logic              unexpected_resp_o
);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       rd_int;
    } tag_entry_t;

    logic [DATA_W-1:0] regfile [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    tag_entry_t          tags [MAX_OUTSTANDING];

    logic [ADDR_W-1:0] rd_fp;
    logic              hazard;
    logic              tag_free;
    logic [TAG_W-1:0]  free_tag;
    logic              accept;

    logic              resp_hit;
    logic [4:0]        resp_rd;
    logic              resp_int;
    logic              resp_fp;
    logic [ADDR_W-1:0] resp_rd_fp;
    logic [CNT_W-1:0]  cnt;

    assign rd_fp = ADDR_W'(req_rd_i);

    // Integer-destination ops only need their FP sources to be ready.
    assign hazard = busy[req_rs1_i] | busy[req_rs2_i]
                  | (req_use_rs3_i & busy[req_rs3_i])
                  | (!req_rd_int_i & busy[rd_fp]);

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        tag_free = 1'b0;
        free_tag = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!tags[i].vld) begin
                tag_free = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            cnt = cnt + CNT_W'(tags[i].vld);
    end
    assign outstanding_o = cnt;

    assign req_ready_o = !rst_i & (!fpu_valid_o | fpu_ready_i) & !hazard & tag_free;
    assign accept      = req_valid_i & req_ready_o;

    // Tag lookup by match rather than direct index keeps out-of-range tags harmless.
    always_comb begin
        resp_hit = 1'b0;
        resp_rd  = '0;
        resp_int = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (fpu_resp_valid_i && tags[i].vld && fpu_resp_tag_i == TAG_W'(i)) begin
                resp_hit = 1'b1;
                resp_rd  = tags[i].rd;
                resp_int = tags[i].rd_int;
            end
        end
    end

    assign resp_fp    = resp_hit & !resp_int;
    assign resp_rd_fp = ADDR_W'(resp_rd);

    assign int_we_o    = !rst_i & resp_hit & resp_int & (resp_rd != 5'd0);
    assign int_waddr_o = resp_rd;
    assign int_wdata_o = fpu_resp_data_i;

    assign dbg_rdata_o = regfile[dbg_raddr_i];

    // Response write is issued last so it wins over a same-address ext write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++)
                regfile[i] <= '0;
        end else begin
            if (ext_we_i)
                regfile[ext_waddr_i] <= ext_wdata_i;
            if (resp_fp)
                regfile[resp_rd_fp] <= fpu_resp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy <= '0;
        end else begin
            if (resp_fp)
                busy[resp_rd_fp] <= 1'b0;
            if (accept && !req_rd_int_i)
                busy[rd_fp] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                tags[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (resp_hit && fpu_resp_tag_i == TAG_W'(i))
                    tags[i].vld <= 1'b0;
                if (accept && free_tag == TAG_W'(i))
                    tags[i] <= tag_entry_t'{vld: 1'b1, rd: req_rd_i, rd_int: req_rd_int_i};
            end
        end
    end

    // Issue register: payload holds until the FPU takes it, reloads on back-to-back accepts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpu_valid_o <= 1'b0;
            fpu_op_o    <= '0;
            fpu_rm_o    <= '0;
            fpu_a_o     <= '0;
            fpu_b_o     <= '0;
            fpu_c_o     <= '0;
            fpu_tag_o   <= '0;
        end else if (accept) begin
            fpu_valid_o <= 1'b1;
            fpu_op_o    <= req_op_i;
            fpu_rm_o    <= req_rm_i;
            fpu_a_o     <= regfile[req_rs1_i];
            fpu_b_o     <= regfile[req_rs2_i];
            fpu_c_o     <= regfile[req_rs3_i];
            fpu_tag_o   <= free_tag;
        end else if (fpu_ready_i) begin
            fpu_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            unexpected_resp_o <= 1'b0;
        else
            unexpected_resp_o <= fpu_resp_valid_i & !resp_hit;
    end

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Bench for fpu_issue_unit: directed scenarios plus a randomized run checked
// against a list-of-pending-ops reference model.
module tb_fpu_issue_unit;

    localparam int DW = 32;
    localparam int OW = 5;
    localparam int MO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o;
    logic [OW-1:0] req_op_i;
    logic [2:0]    req_rm_i;
    logic [4:0]    req_rs1_i, req_rs2_i, req_rs3_i;
    logic          req_use_rs3_i;
    logic [4:0]    req_rd_i;
    logic          req_rd_int_i;
    logic          fpu_valid_o, fpu_ready_i;
    logic [OW-1:0] fpu_op_o;
    logic [2:0]    fpu_rm_o;
    logic [DW-1:0] fpu_a_o, fpu_b_o, fpu_c_o;
    logic [1:0]    fpu_tag_o;
    logic          fpu_resp_valid_i;
    logic [1:0]    fpu_resp_tag_i;
    logic [DW-1:0] fpu_resp_data_i;
    logic          int_we_o;
    logic [4:0]    int_waddr_o;
    logic [DW-1:0] int_wdata_o;
    logic          ext_we_i;
    logic [4:0]    ext_waddr_i;
    logic [DW-1:0] ext_wdata_i;
    logic [4:0]    dbg_raddr_i;
    logic [DW-1:0] dbg_rdata_o;
    logic [2:0]    outstanding_o;
    logic          unexpected_resp_o;

    int checks = 0;
    int errors = 0;

    fpu_issue_unit #(.DATA_W(DW), .NUM_REGS(32), .OP_W(OW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rm_i(req_rm_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_rs3_i(req_rs3_i), .req_use_rs3_i(req_use_rs3_i), .req_rd_i(req_rd_i),
        .req_rd_int_i(req_rd_int_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_op_o(fpu_op_o),
        .fpu_rm_o(fpu_rm_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_c_o(fpu_c_o),
        .fpu_tag_o(fpu_tag_o),
        .fpu_resp_valid_i(fpu_resp_valid_i), .fpu_resp_tag_i(fpu_resp_tag_i),
        .fpu_resp_data_i(fpu_resp_data_i),
        .int_we_o(int_we_o), .int_waddr_o(int_waddr_o), .int_wdata_o(int_wdata_o),
        .ext_we_i(ext_we_i), .ext_waddr_i(ext_waddr_i), .ext_wdata_i(ext_wdata_i),
        .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o),
        .outstanding_o(outstanding_o), .unexpected_resp_o(unexpected_resp_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: register values plus the set of in-flight ops.
    typedef struct {
        int tag;
        int rd;
        bit rd_int;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] m_rf [32];

    function automatic void m_reset();
        pend.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endfunction

    function automatic bit m_busy(int r);
        foreach (pend[i]) if (!pend[i].rd_int && pend[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_free_tag();
        for (int t = 0; t < MO; t++) begin
            bit used = 1'b0;
            foreach (pend[i]) if (pend[i].tag == t) used = 1'b1;
            if (!used) return t;
        end
        return -1;
    endfunction

    function automatic bit m_hazard(int rs1, int rs2, int rs3, bit use3, int rd, bit rdint);
        return m_busy(rs1) || m_busy(rs2) || (use3 && m_busy(rs3)) || (!rdint && m_busy(rd));
    endfunction

    function automatic void m_push(int tag, int rd, bit rdint);
        pend.push_back('{tag: tag, rd: rd, rd_int: rdint});
    endfunction

    function automatic void m_complete(int tag, logic [31:0] data);
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].tag == tag) begin
                if (!pend[i].rd_int) m_rf[pend[i].rd] = data;
                pend.delete(i);
                return;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input int op, input int rs1, input int rs2, input int rs3,
                             input bit use3, input int rd, input bit rdint);
        req_valid_i   = 1'b1;
        req_op_i      = OW'(op);
        req_rm_i      = 3'($urandom_range(0, 7));
        req_rs1_i     = 5'(rs1);
        req_rs2_i     = 5'(rs2);
        req_rs3_i     = 5'(rs3);
        req_use_rs3_i = use3;
        req_rd_i      = 5'(rd);
        req_rd_int_i  = rdint;
    endtask

    task automatic ext_write(input int addr, input logic [31:0] data);
        ext_we_i    = 1'b1;
        ext_waddr_i = 5'(addr);
        ext_wdata_i = data;
        step();
        ext_we_i    = 1'b0;
        m_rf[addr]  = data;
    endtask

    // Waits (bounded) for acceptance and returns the payload seen in the following cycle.
    task automatic issue(input int op, input int rs1, input int rs2, input int rs3, input bit use3,
                         input int rd, input bit rdint, output bit ok,
                         output logic [31:0] a, output logic [31:0] b, output logic [1:0] tag);
        int t;
        ok = 1'b0; a = '0; b = '0; tag = '0;
        drive_req(op, rs1, rs2, rs3, use3, rd, rdint);
        for (int k = 0; k < 50; k++) begin
            #1;
            if (req_ready_o === 1'b1) begin
                t = m_free_tag();
                step();
                a   = fpu_a_o;
                b   = fpu_b_o;
                tag = fpu_tag_o;
                ok  = fpu_valid_o;
                m_push(t, rd, rdint);
                break;
            end
            step();
        end
        req_valid_i = 1'b0;
    endtask

    task automatic respond(input int tag, input logic [31:0] data,
                           output bit we, output logic [4:0] wa, output logic [31:0] wd);
        fpu_resp_valid_i = 1'b1;
        fpu_resp_tag_i   = 2'(tag);
        fpu_resp_data_i  = data;
        #1;
        we = int_we_o; wa = int_waddr_o; wd = int_wdata_o;
        step();
        fpu_resp_valid_i = 1'b0;
        m_complete(tag, data);
    endtask

    task automatic drain();
        bit we; logic [4:0] wa; logic [31:0] wd;
        while (pend.size() > 0) respond(pend[0].tag, $urandom, we, wa, wd);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_req(1, 1, 2, 3, 1'b1, 4, 1'b0);
        step(); step();
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready_o); end
        checks++; if (fpu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fpu_valid got %b exp 0", fpu_valid_o); end
        checks++; if ({fpu_a_o, fpu_b_o, fpu_c_o, fpu_op_o, fpu_rm_o, fpu_tag_o} !== '0) begin errors++; $display("FAIL reset_payload got %h/%h/%h exp 0", fpu_a_o, fpu_b_o, fpu_c_o); end
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); end
        checks++; if (unexpected_resp_o !== 1'b0 || int_we_o !== 1'b0) begin errors++; $display("FAIL reset_flags got unexp=%b int_we=%b exp 0", unexpected_resp_o, int_we_o); end
        req_valid_i = 1'b0;
        rst_i = 1'b0;
        m_reset();
        step();
        dbg_raddr_i = 5'd7; #1;
        checks++; if (dbg_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_regfile got %h exp 0", dbg_rdata_o); end
    endtask

    task automatic test_basic();
        bit ok; logic [31:0] a, b; logic [1:0] tag;
        bit we; logic [4:0] wa; logic [31:0] wd;
        ext_write(1, 32'h4023D70A);
        ext_write(2, 32'h41200000);
        issue(0, 1, 2, 0, 1'b0, 3, 1'b0, ok, a, b, tag);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout exp accept"); end
        checks++; if (a !== 32'h4023D70A || b !== 32'h41200000) begin errors++; $display("FAIL basic_operands got %h %h exp 4023d70a 41200000", a, b); end
        checks++; if (tag !== 2'd0) begin errors++; $display("FAIL basic_tag got %0d exp 0", tag); end
        respond(0, 32'h4148F5C3, we, wa, wd);
        dbg_raddr_i = 5'd3; #1;
        checks++; if (dbg_rdata_o !== 32'h4148F5C3) begin errors++; $display("FAIL basic_writeback got %h exp 4148f5c3", dbg_rdata_o); end
        drive_req(0, 3, 3, 3, 1'b1, 3, 1'b0); #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL basic_busy_clear got ready %b exp 1", req_ready_o); end
        req_valid_i = 1'b0;
    endtask

    task automatic test_raw();
        bit ok; logic [31:0] a, b; logic [1:0] tag;
        issue(1, 1, 2, 0, 1'b0, 4, 1'b0, ok, a, b, tag);
        drive_req(1, 3, 4, 0, 1'b0, 5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall cyc=%0d got %b exp 0", k, req_ready_o); end
            step();
        end
        fpu_resp_valid_i = 1'b1; fpu_resp_tag_i = 2'd0; fpu_resp_data_i = 32'hC0EE147B;
        #1;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got %b exp 0", req_ready_o); end
        step();
        fpu_resp_valid_i = 1'b0;
        m_complete(0, 32'hC0EE147B);
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", req_ready_o); end
        step();
        req_valid_i = 1'b0;
        m_push(0, 5, 1'b0);
        checks++; if (fpu_valid_o !== 1'b1 || fpu_a_o !== 32'h4148F5C3 || fpu_b_o !== 32'hC0EE147B || fpu_tag_o !== 2'd0) begin
            errors++; $display("FAIL raw_payload got v=%b %h %h t=%0d exp 1 4148f5c3 c0ee147b 0", fpu_valid_o, fpu_a_o, fpu_b_o, fpu_tag_o); end
        drain();
    endtask

    task automatic test_ooo();
        bit ok; logic [31:0] a, b; logic [1:0] t0, t1;
        bit we; logic [4:0] wa; logic [31:0] wd;
        logic [31:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        issue(2, 1, 2, 0, 1'b0, 6, 1'b0, ok, a, b, t0);
        issue(0, 1, 2, 0, 1'b0, 7, 1'b0, ok, a, b, t1);
        checks++; if (t0 !== 2'd0 || t1 !== 2'd1) begin errors++; $display("FAIL ooo_tags got %0d %0d exp 0 1", t0, t1); end
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL ooo_cnt2 got %0d exp 2", outstanding_o); end
        respond(1, d1, we, wa, wd);
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL ooo_cnt1 got %0d exp 1", outstanding_o); end
        respond(0, d0, we, wa, wd);
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL ooo_cnt0 got %0d exp 0", outstanding_o); end
        dbg_raddr_i = 5'd7; #1;
        checks++; if (dbg_rdata_o !== d1) begin errors++; $display("FAIL ooo_r7 got %h exp %h", dbg_rdata_o, d1); end
        dbg_raddr_i = 5'd6; #1;
        checks++; if (dbg_rdata_o !== d0) begin errors++; $display("FAIL ooo_r6 got %h exp %h", dbg_rdata_o, d0); end
    endtask

    task automatic test_backpressure();
        bit ok; logic [31:0] a, b, old_r1; logic [1:0] tag;
        bit we; logic [4:0] wa; logic [31:0] wd;
        int et;
        fpu_ready_i = 1'b0;
        old_r1 = m_rf[1];
        issue(3, 1, 2, 0, 1'b0, 8, 1'b0, ok, a, b, tag);
        ext_write(1, $urandom);
        drive_req(3, 1, 2, 0, 1'b0, 9, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready_o !== 1'b0 || fpu_valid_o !== 1'b1 || fpu_a_o !== old_r1 || fpu_tag_o !== 2'd0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b a=%h t=%0d exp 0 1 %h 0", k, req_ready_o, fpu_valid_o, fpu_a_o, fpu_tag_o, old_r1); end
            step();
        end
        fpu_ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", req_ready_o); end
        et = m_free_tag();
        step();
        req_valid_i = 1'b0;
        m_push(et, 9, 1'b0);
        checks++; if (fpu_tag_o !== 2'(et) || fpu_a_o !== m_rf[1]) begin errors++; $display("FAIL bp_reload got t=%0d a=%h exp %0d %h", fpu_tag_o, fpu_a_o, et, m_rf[1]); end
        issue(3, 1, 2, 0, 1'b0, 10, 1'b0, ok, a, b, tag);
        issue(3, 1, 2, 0, 1'b0, 11, 1'b0, ok, a, b, tag);
        checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL bp_full_cnt got %0d exp 4", outstanding_o); end
        drive_req(3, 1, 2, 0, 1'b0, 12, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_no_tag cyc=%0d got %b exp 0", k, req_ready_o); end
            step();
        end
        respond(2, $urandom, we, wa, wd);
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_tag_freed got %b exp 1", req_ready_o); end
        et = m_free_tag();
        step();
        req_valid_i = 1'b0;
        m_push(et, 12, 1'b0);
        checks++; if (fpu_tag_o !== 2'd2) begin errors++; $display("FAIL bp_tag_reuse got %0d exp 2", fpu_tag_o); end
        drain();
    endtask

    task automatic test_int_dest();
        bit ok; logic [31:0] a, b; logic [1:0] tag;
        bit we; logic [4:0] wa; logic [31:0] wd;
        issue(4, 1, 2, 0, 1'b0, 5, 1'b1, ok, a, b, tag);
        respond(int'(tag), 32'h17, we, wa, wd);
        checks++; if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'h17) begin errors++; $display("FAIL int_wb got we=%b a=%0d d=%h exp 1 5 17", we, wa, wd); end
        dbg_raddr_i = 5'd5; #1;
        checks++; if (dbg_rdata_o !== m_rf[5]) begin errors++; $display("FAIL int_fp_untouched got %h exp %h", dbg_rdata_o, m_rf[5]); end
        issue(4, 1, 2, 0, 1'b0, 0, 1'b1, ok, a, b, tag);
        respond(int'(tag), 32'h17, we, wa, wd);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL int_x0 got we=%b exp 0", we); end
    endtask

    task automatic test_unexpected();
        bit we; logic [4:0] wa; logic [31:0] wd;
        dbg_raddr_i = 5'd3;
        respond(2, 32'hDEADBEEF, we, wa, wd);
        checks++; if (unexpected_resp_o !== 1'b1) begin errors++; $display("FAIL unexp_pulse got %b exp 1", unexpected_resp_o); end
        checks++; if (dbg_rdata_o !== m_rf[3] || we !== 1'b0) begin errors++; $display("FAIL unexp_nostate got r3=%h we=%b exp %h 0", dbg_rdata_o, we, m_rf[3]); end
        step();
        checks++; if (unexpected_resp_o !== 1'b0) begin errors++; $display("FAIL unexp_oneshot got %b exp 0", unexpected_resp_o); end
    endtask

    task automatic test_collision();
        bit ok; logic [31:0] a, b; logic [1:0] tag;
        issue(0, 1, 2, 0, 1'b0, 15, 1'b0, ok, a, b, tag);
        fpu_resp_valid_i = 1'b1; fpu_resp_tag_i = tag; fpu_resp_data_i = 32'h3F800000;
        ext_we_i = 1'b1; ext_waddr_i = 5'd15; ext_wdata_i = 32'h12345678;
        step();
        fpu_resp_valid_i = 1'b0; ext_we_i = 1'b0;
        m_rf[15] = 32'h12345678;
        m_complete(int'(tag), 32'h3F800000);
        dbg_raddr_i = 5'd15; #1;
        checks++; if (dbg_rdata_o !== m_rf[15]) begin errors++; $display("FAIL collision got %h exp %h", dbg_rdata_o, m_rf[15]); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [31:0] a, b; logic [1:0] tag;
        bit we; logic [4:0] wa; logic [31:0] wd;
        issue(0, 1, 2, 0, 1'b0, 13, 1'b0, ok, a, b, tag);
        issue(0, 1, 2, 0, 1'b0, 14, 1'b0, ok, a, b, tag);
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL rstmid_pre got %0d exp 2", outstanding_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        m_reset();
        #1;
        checks++; if (outstanding_o !== 3'd0 || fpu_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_clear got cnt=%0d v=%b exp 0 0", outstanding_o, fpu_valid_o); end
        drive_req(0, 13, 14, 13, 1'b1, 14, 1'b0); #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy got ready %b exp 1", req_ready_o); end
        req_valid_i = 1'b0;
        dbg_raddr_i = 5'd13;
        respond(0, 32'hCAFEF00D, we, wa, wd);
        checks++; if (unexpected_resp_o !== 1'b1 || dbg_rdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_stale got unexp=%b r13=%h exp 1 0", unexpected_resp_o, dbg_rdata_o); end
    endtask

    task automatic test_random();
        bit full;
        full = 1'b0;
        for (int r = 1; r <= 6; r++) ext_write(r, $urandom);
        fpu_ready_i = 1'b1;
        step(); step();
        for (int it = 0; it < 250; it++) begin
            int rs1, rs2, rs3, rd, ridx, rtag, eaddr, daddr, etag;
            bit use3, rdint, dresp, dext, exp_rdy, exp_unexp, exp_we, acc;
            logic [31:0] rdata, edata, ea, eb, ec;
            logic [2:0] erm; logic [OW-1:0] eop;
            fpu_ready_i = ($urandom_range(0, 3) != 0);
            rs1 = $urandom_range(1, 6); rs2 = $urandom_range(1, 6); rs3 = $urandom_range(1, 6);
            use3 = 1'($urandom_range(0, 1));
            rdint = ($urandom_range(0, 3) == 0);
            rd = rdint ? $urandom_range(0, 6) : $urandom_range(1, 6);
            drive_req($urandom_range(0, 31), rs1, rs2, rs3, use3, rd, rdint);
            req_valid_i = 1'($urandom_range(0, 1));
            dresp = 1'b0; exp_unexp = 1'b0; ridx = 0; rtag = 0;
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                ridx = $urandom_range(0, pend.size() - 1);
                rtag = pend[ridx].tag;
                dresp = 1'b1;
            end else if (pend.size() < MO && $urandom_range(0, 9) == 0) begin
                rtag = m_free_tag();
                dresp = 1'b1; exp_unexp = 1'b1;
            end
            rdata = $urandom;
            fpu_resp_valid_i = dresp; fpu_resp_tag_i = 2'(rtag); fpu_resp_data_i = rdata;
            dext = ($urandom_range(0, 4) == 0); eaddr = $urandom_range(1, 6); edata = $urandom;
            ext_we_i = dext; ext_waddr_i = 5'(eaddr); ext_wdata_i = edata;
            daddr = $urandom_range(0, 7); dbg_raddr_i = 5'(daddr);
            #1;
            exp_rdy = (!full || fpu_ready_i) && !m_hazard(rs1, rs2, rs3, use3, rd, rdint) && pend.size() < MO;
            checks++; if (req_ready_o !== exp_rdy) begin errors++; $display("FAIL rnd_ready it=%0d got %b exp %b", it, req_ready_o, exp_rdy); end
            checks++; if (outstanding_o !== 3'(pend.size())) begin errors++; $display("FAIL rnd_cnt it=%0d got %0d exp %0d", it, outstanding_o, pend.size()); end
            exp_we = dresp && !exp_unexp && pend[ridx].rd_int && pend[ridx].rd != 0;
            checks++; if (int_we_o !== exp_we || (exp_we && (int_waddr_o !== 5'(pend[ridx].rd) || int_wdata_o !== rdata))) begin
                errors++; $display("FAIL rnd_int it=%0d got we=%b a=%0d d=%h exp we=%b", it, int_we_o, int_waddr_o, int_wdata_o, exp_we); end
            acc = req_valid_i && exp_rdy;
            etag = m_free_tag();
            ea = m_rf[rs1]; eb = m_rf[rs2]; ec = m_rf[rs3]; erm = req_rm_i; eop = req_op_i;
            step();
            if (dext) m_rf[eaddr] = edata;
            if (dresp && !exp_unexp) m_complete(rtag, rdata);
            if (acc) begin
                m_push(etag, rd, rdint);
                full = 1'b1;
                checks++; if (fpu_a_o !== ea || fpu_b_o !== eb || fpu_c_o !== ec || fpu_tag_o !== 2'(etag) || fpu_op_o !== eop || fpu_rm_o !== erm) begin
                    errors++; $display("FAIL rnd_payload it=%0d got %h %h %h t=%0d exp %h %h %h t=%0d", it, fpu_a_o, fpu_b_o, fpu_c_o, fpu_tag_o, ea, eb, ec, etag); end
            end else if (fpu_ready_i) begin
                full = 1'b0;
            end
            checks++; if (fpu_valid_o !== full) begin errors++; $display("FAIL rnd_valid it=%0d got %b exp %b", it, fpu_valid_o, full); end
            checks++; if (unexpected_resp_o !== exp_unexp) begin errors++; $display("FAIL rnd_unexp it=%0d got %b exp %b", it, unexpected_resp_o, exp_unexp); end
            checks++; if (dbg_rdata_o !== m_rf[daddr]) begin errors++; $display("FAIL rnd_rf it=%0d r%0d got %h exp %h", it, daddr, dbg_rdata_o, m_rf[daddr]); end
            req_valid_i = 1'b0; fpu_resp_valid_i = 1'b0; ext_we_i = 1'b0;
        end
        fpu_ready_i = 1'b1;
        drain();
        #1;
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL rnd_drain got %0d exp 0", outstanding_o); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_op_i = '0; req_rm_i = '0;
        req_rs1_i = '0; req_rs2_i = '0; req_rs3_i = '0; req_use_rs3_i = 1'b0;
        req_rd_i = '0; req_rd_int_i = 1'b0;
        fpu_ready_i = 1'b1;
        fpu_resp_valid_i = 1'b0; fpu_resp_tag_i = '0; fpu_resp_data_i = '0;
        ext_we_i = 1'b0; ext_waddr_i = '0; ext_wdata_i = '0;
        dbg_raddr_i = '0;
        m_reset();
        test_reset();
        test_basic();
        test_raw();
        test_ooo();
        test_backpressure();
        test_int_dest();
        test_unexpected();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
